// File: rtl/hazard_ctrl.sv
// Decode-stage hazard unit: ages writer timing tags through E/M/W, raises stall and picks forwarding sources.
// Optional macro HAZARD_MDU_STALL_EN adds the multiply/divide busy tracker and its stall term.
`timescale 1ns/1ps
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       d_valid,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [2:0] d_tuse_rs,
  input  logic [2:0] d_tuse_rt,
  input  logic [2:0] d_tnew,
  input  logic [4:0] d_dst,
  input  logic       d_is_md,
  input  logic [1:0] d_md_kind,
  output logic       stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic       md_busy
);

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [2:0] tnew;
  } e_stage_t;

  // Only E needs its sources; M and W are consulted purely as writers.
  e_stage_t   e_q;
  logic [4:0] m_dst;
  logic [2:0] m_tnew;
  logic [4:0] w_dst;
  logic [2:0] w_tnew;
  logic       hazard;
  logic       md_stall;

  function automatic logic [2:0] dec_sat(input logic [2:0] v);
    return (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  function automatic logic raw_hit(input logic [4:0] dst, input logic [2:0] tnew,
                                   input logic [4:0] src, input logic [2:0] tuse);
    return (src != 5'd0) && (tuse < 3'd5) && (dst == src) && (tnew > tuse);
  endfunction

  // Youngest matching writer decides; a match that is not ready yields 0 and the stall covers it.
  function automatic logic [1:0] pick(input logic [4:0] src, input logic look_e,
                                      input logic [4:0] ed, input logic [2:0] et,
                                      input logic [4:0] md, input logic [2:0] mt,
                                      input logic [4:0] wd, input logic [2:0] wt);
    if (src == 5'd0) return 2'd0;
    if (look_e && ed == src) return (et == 3'd0) ? 2'd1 : 2'd0;
    if (md == src) return (mt == 3'd0) ? 2'd2 : 2'd0;
    if (wd == src) return (wt == 3'd0) ? 2'd3 : 2'd0;
    return 2'd0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      e_q    <= '0;
      m_dst  <= '0;
      m_tnew <= '0;
      w_dst  <= '0;
      w_tnew <= '0;
    end else begin
      if (stall || !d_valid) begin
        e_q <= '0;
      end else begin
        e_q <= '{rs: d_rs, rt: d_rt, dst: d_dst, tnew: dec_sat(d_tnew)};
      end
      m_dst  <= e_q.dst;
      m_tnew <= dec_sat(e_q.tnew);
      w_dst  <= m_dst;
      w_tnew <= dec_sat(m_tnew);
    end
  end

  always_comb begin
    hazard = 1'b0;
    hazard = raw_hit(e_q.dst, e_q.tnew, d_rs, d_tuse_rs)
           | raw_hit(e_q.dst, e_q.tnew, d_rt, d_tuse_rt)
           | raw_hit(m_dst, m_tnew, d_rs, d_tuse_rs)
           | raw_hit(m_dst, m_tnew, d_rt, d_tuse_rt);
  end

  assign stall = hazard | md_stall;

  assign fwd_d_rs = pick(d_rs, 1'b1, e_q.dst, e_q.tnew, m_dst, m_tnew, w_dst, w_tnew);
  assign fwd_d_rt = pick(d_rt, 1'b1, e_q.dst, e_q.tnew, m_dst, m_tnew, w_dst, w_tnew);
  assign fwd_e_rs = pick(e_q.rs, 1'b0, e_q.dst, e_q.tnew, m_dst, m_tnew, w_dst, w_tnew);
  assign fwd_e_rt = pick(e_q.rt, 1'b0, e_q.dst, e_q.tnew, m_dst, m_tnew, w_dst, w_tnew);

`ifdef HAZARD_MDU_STALL_EN
  localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW     = $clog2(MD_MAX + 1);

  logic [1:0]    e_md;
  logic [CW-1:0] md_cnt;

  // A start loads the counter on the edge that leaves E; a fresh load overrides any residue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      e_md   <= 2'd0;
      md_cnt <= '0;
    end else begin
      e_md <= (stall || !d_valid) ? 2'd0 : d_md_kind;
      if (e_md == 2'd1) begin
        md_cnt <= CW'(MULT_CYCLES);
      end else if (e_md == 2'd2) begin
        md_cnt <= CW'(DIV_CYCLES);
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - CW'(1);
      end
    end
  end

  assign md_busy  = (md_cnt != '0);
  assign md_stall = d_is_md & (md_busy | (e_md != 2'd0));
`else
  logic unused_md;
  assign unused_md = ^{d_is_md, d_md_kind};
  assign md_busy   = 1'b0;
  assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed timing scenarios with literal expectations, then random traffic
// checked every cycle against an instruction-history model (results ready at D-cycle + tnew).
`timescale 1ns/1ps
module tb_hazard_ctrl;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       d_valid = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_dst = '0;
  logic [2:0] d_tuse_rs = '0, d_tuse_rt = '0, d_tnew = '0;
  logic       d_is_md = 1'b0;
  logic [1:0] d_md_kind = '0;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_tnew(d_tnew), .d_dst(d_dst), .d_is_md(d_is_md), .d_md_kind(d_md_kind),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .md_busy(md_busy)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model: history of instructions issued from D ----------------
  typedef struct {
    bit v;
    int dc;
    int dst;
    int tnew;
    int rs;
    int rt;
    int md;
  } hist_t;

  hist_t hist[8];
  bit    md_v = 1'b0;
  int    md_e = 0;
  int    md_n = 0;
  hist_t he;
  bit    xs, xbusy;

  function automatic hist_t at(input int a);
    hist_t h;
    bit [2:0] ix;
    ix = 3'((cyc - a) & 7);
    h = hist[ix];
    if (!(h.v && h.dc == cyc - a)) h = '{default: 0};
    return h;
  endfunction

  function automatic int rem(input hist_t h);
    int r;
    r = h.tnew - (cyc - h.dc);
    return (r < 0) ? 0 : r;
  endfunction

  function automatic bit src_stall(input int src, input int tuse);
    hist_t h;
    if (src == 0 || tuse >= 5) return 1'b0;
    for (int a = 1; a <= 2; a++) begin
      h = at(a);
      if (h.v && h.dst == src && rem(h) > tuse) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int fwd_from(input int src, input int first_age);
    hist_t h;
    if (src == 0) return 0;
    for (int a = first_age; a <= 3; a++) begin
      h = at(a);
      if (h.v && h.dst == src) return (rem(h) == 0) ? a : 0;
    end
    return 0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 8; i++) hist[i] = '{default: 0};
    md_v = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      clear_model();
    end else begin
      he = at(1);
      xs = src_stall(int'(d_rs), int'(d_tuse_rs)) || src_stall(int'(d_rt), int'(d_tuse_rt));
`ifdef HAZARD_MDU_STALL_EN
      xbusy = md_v && (cyc > md_e) && (cyc <= md_e + md_n);
      xs = xs || (d_is_md && (xbusy || he.md != 0));
`else
      xbusy = 1'b0;
`endif
      if (!flush) chk("stall", int'(stall), int'(xs));
      chk("fwd_d_rs", int'(fwd_d_rs), fwd_from(int'(d_rs), 1));
      chk("fwd_d_rt", int'(fwd_d_rt), fwd_from(int'(d_rt), 1));
      chk("fwd_e_rs", int'(fwd_e_rs), fwd_from(he.rs, 2));
      chk("fwd_e_rt", int'(fwd_e_rt), fwd_from(he.rt, 2));
      chk("md_busy", int'(md_busy), int'(xbusy));
      if (flush) begin
        clear_model();
      end else if (d_valid && !xs) begin
        hist[3'(cyc & 7)] = '{v: 1'b1, dc: cyc, dst: int'(d_dst), tnew: int'(d_tnew),
                              rs: int'(d_rs), rt: int'(d_rt), md: int'(d_md_kind)};
        if (d_md_kind == 2'd1 || d_md_kind == 2'd2) begin
          md_v = 1'b1;
          md_e = cyc + 1;
          md_n = (d_md_kind == 2'd1) ? MULT_N : DIV_N;
        end
      end
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input bit v, input int rs, input int rt, input int tuse_rs, input int tuse_rt,
                       input int tnew, input int dst, input bit is_md, input int kind);
    d_valid   = v;
    d_rs      = 5'(rs);
    d_rt      = 5'(rt);
    d_tuse_rs = 3'(tuse_rs);
    d_tuse_rt = 3'(tuse_rt);
    d_tnew    = 3'(tnew);
    d_dst     = 5'(dst);
    d_is_md   = is_md;
    d_md_kind = 2'(kind);
  endtask

  task automatic idle();
    set_d(1'b0, 0, 0, 5, 5, 0, 0, 1'b0, 0);
  endtask

  int  n_stall, n_busy;
  bit  done;

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_stall", int'(stall), 0);
    chk("rst_fwd_d", int'({fwd_d_rs, fwd_d_rt}), 0);
    chk("rst_fwd_e", int'({fwd_e_rs, fwd_e_rt}), 0);
    chk("rst_md_busy", int'(md_busy), 0);

    // addu $3 then beq on $3: one stall, then forward from M
    tick(); set_d(1'b1, 1, 2, 1, 1, 2, 3, 1'b0, 0);
    tick(); set_d(1'b1, 3, 0, 0, 0, 0, 0, 1'b0, 0);
    @(negedge clk); chk("t1_stall", int'(stall), 1);
    tick(); @(negedge clk);
    chk("t1_unstall", int'(stall), 0);
    chk("t1_fwd_d_rs", int'(fwd_d_rs), 2);
    tick(); idle(); repeat (3) tick();

    // lw $5 then addu rs=$5: one stall, then E forwards from W
    tick(); set_d(1'b1, 29, 0, 1, 5, 3, 5, 1'b0, 0);
    tick(); set_d(1'b1, 5, 6, 1, 1, 2, 7, 1'b0, 0);
    @(negedge clk); chk("t2_stall", int'(stall), 1);
    tick(); @(negedge clk);
    chk("t2_unstall", int'(stall), 0);
    chk("t2_fwd_d_rs", int'(fwd_d_rs), 0);
    tick(); idle(); @(negedge clk);
    chk("t2_fwd_e_rs", int'(fwd_e_rs), 3);
    chk("t2_fwd_e_rt", int'(fwd_e_rt), 0);
    repeat (3) tick();

    // writer of $0 never creates a hazard
    tick(); set_d(1'b1, 0, 0, 1, 5, 2, 0, 1'b0, 0);
    tick(); set_d(1'b1, 0, 0, 0, 0, 0, 0, 1'b0, 0);
    @(negedge clk);
    chk("t3_stall", int'(stall), 0);
    chk("t3_fwd_d_rs", int'(fwd_d_rs), 0);
    tick(); idle(); repeat (3) tick();

    // $4 written twice, sw rt=$4 tuse 2: no stall, youngest (M) wins in E
    tick(); set_d(1'b1, 1, 2, 1, 1, 2, 4, 1'b0, 0);
    tick(); set_d(1'b1, 1, 2, 1, 1, 2, 4, 1'b0, 0);
    tick(); set_d(1'b1, 29, 4, 1, 2, 0, 0, 1'b0, 0);
    @(negedge clk);
    chk("t4_stall", int'(stall), 0);
    chk("t4_fwd_d_rt", int'(fwd_d_rt), 0);
    tick(); idle(); @(negedge clk);
    chk("t4_fwd_e_rt", int'(fwd_e_rt), 2);
    chk("t4_fwd_e_rs", int'(fwd_e_rs), 0);
    repeat (3) tick();

    // flush together with a load-use stall clears everything
    tick(); set_d(1'b1, 29, 0, 1, 5, 3, 8, 1'b0, 0);
    tick(); set_d(1'b1, 8, 0, 0, 0, 2, 9, 1'b0, 0); flush = 1'b1;
    tick(); flush = 1'b0; @(negedge clk);
    chk("t6_stall", int'(stall), 0);
    chk("t6_fwd_d", int'({fwd_d_rs, fwd_d_rt}), 0);
    chk("t6_fwd_e", int'({fwd_e_rs, fwd_e_rt}), 0);
    tick(); idle(); repeat (3) tick();

    // div then mflo
    tick(); set_d(1'b1, 1, 2, 1, 1, 0, 0, 1'b1, 2);
    tick(); set_d(1'b1, 0, 0, 5, 5, 1, 2, 1'b1, 0);
    n_stall = 0; n_busy = 0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (md_busy) n_busy++;
      if (!stall) done = 1'b1;
      else tick();
    end
    chk("t5_done", int'(done), 1);
`ifdef HAZARD_MDU_STALL_EN
    chk("t5_stall_cycles", n_stall, 11);
    chk("t5_busy_cycles", n_busy, 10);
`else
    chk("t5_stall_cycles", n_stall, 0);
    chk("t5_busy_cycles", n_busy, 0);
`endif
    tick(); idle(); repeat (3) tick();

    // reset in the middle of a divide
    tick(); set_d(1'b1, 1, 2, 1, 1, 0, 0, 1'b1, 2);
    tick(); idle();
    tick(); @(negedge clk);
`ifdef HAZARD_MDU_STALL_EN
    chk("t6_busy_mid", int'(md_busy), 1);
`else
    chk("t6_busy_mid", int'(md_busy), 0);
`endif
    tick(); reset = 1'b1;
    tick(); reset = 1'b0; @(negedge clk);
    chk("t6_busy_after_rst", int'(md_busy), 0);
    chk("t6_stall_after_rst", int'(stall), 0);

    // random traffic over a small register window so dependencies are frequent
    for (int i = 0; i < 2000; i++) begin
      tick();
      set_d($urandom_range(0, 9) < 8, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 7)), $urandom_range(0, 9) == 0,
            ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0);
      flush = ($urandom_range(0, 99) < 3);
    end
    tick(); flush = 1'b0; idle();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
